mips_regfile_sb: RTL and testbench
==================================

Name: mips_regfile_sb

Overview:
Parametrised successor to the single-cycle MIPS register file for the pipelined datapath. It provides two combinational read ports, one general writeback port and a dedicated link (Jal) write port with a configurable link register and increment. A busy-bit scoreboard lets decode detect pending producers. After reset, a clear sequencer zeroes the array before the block reports ready.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
LINK_REG, 31, index written by the link port ($ra)
LINK_INC, 1, added to LinkAddr before the link write (word-addressed PC)

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  asynchronous reset, active-high
ReadReg1  in  ADDR_W  read port 1 index
ReadReg2  in  ADDR_W  read port 2 index
DataRead1  out  DATA_W  read port 1 data
DataRead2  out  DATA_W  read port 2 data
WriteReg  in  ADDR_W  writeback index
WriteData  in  DATA_W  writeback data
RegWrite  in  1  writeback enable
LinkWrite  in  1  link write enable (Jal)
LinkAddr  in  DATA_W  PC of the link instruction
IssueValid  in  1  an instruction that will write IssueReg is issued
IssueReg  in  ADDR_W  destination of the issued instruction
Busy1  out  1  busy[ReadReg1]
Busy2  out  1  busy[ReadReg2]
Ready  out  1  clear sequence complete; array usable

Behaviour:
- FSM with states CLEAR and RUN. Rst (async) forces CLEAR, clear pointer to 0, Ready=0 and all busy bits to 0. Array contents are not reset directly.
- CLEAR: each Clk writes 0 to regs[ptr] and increments ptr. After the write to DEPTH-1, the next state is RUN. Ready=1 exactly DEPTH cycles after Rst deasserts (32 by default).
- In CLEAR, RegWrite, LinkWrite and IssueValid are ignored. DataRead1/2 return 0 and Busy1/2 return 0.
- Rst asserted mid-CLEAR or mid-RUN restarts the clear from ptr 0.
- RUN writes (posedge): if RegWrite and WriteReg!=0, regs[WriteReg]<=WriteData. If LinkWrite, regs[LINK_REG]<=LinkAddr+LINK_INC, truncated to DATA_W (wraps).
- If RegWrite targets LINK_REG in the same cycle as LinkWrite, LinkWrite wins.
- Writes to index 0 are discarded. If LINK_REG=0, the link write is discarded.
- Reads are combinational. An index of 0 always returns 0. Otherwise the read returns regs[idx], subject to bypass (see Optional Feature).
- Scoreboard (RUN only): IssueValid with IssueReg!=0 sets busy[IssueReg]. RegWrite with WriteReg!=0 clears busy[WriteReg]. LinkWrite clears busy[LINK_REG].
- Set and clear of the same index in the same cycle: set wins, because the new producer is outstanding.
- busy[0] is never set.
- Busy1/2 are combinational from the registered busy bits. They show the pre-edge state: a same-cycle writeback does not clear the Busy output in that cycle.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined, in RUN: a read of an index being written this cycle returns the incoming value (write-through). A link write to LINK_REG has priority over RegWrite data. Index 0 still returns 0.
- Not defined: reads return the pre-edge array contents; new data is visible the cycle after the write.
- Scoreboard and Busy timing are identical in both builds.

Test Plan:
- Reset then idle: deassert Rst → Ready=0 for 32 cycles, then 1; every index reads 0x00000000.
- RegWrite WriteReg=5, WriteData=0xDEADBEEF; ReadReg1=5 the same cycle → with REGFILE_BYPASS_EN 0xDEADBEEF, without it the old value. Next cycle 0xDEADBEEF in both builds.
- Write 0x12345678 to reg 0 → DataRead1 with ReadReg1=0 stays 0.
- LinkWrite with LinkAddr=0x00400010, plus RegWrite to 31 with 0xAAAA0000, same cycle → regs[31]=0x00400011. LinkAddr=0xFFFFFFFF → regs[31]=0x00000000.
- IssueValid IssueReg=7 → next cycle Busy1=1 with ReadReg1=7. Next, RegWrite 7 with IssueValid 7 in the same cycle → busy stays 1. Then RegWrite 7 alone → Busy1=0 the following cycle.
- Assert Rst during RUN with busy[7]=1 → Busy1=0 and Ready=0 immediately. Clear completes after 32 cycles, and reg 5 then reads 0.

Source files
------------

// File: rtl/mips_regfile_sb.sv
// Pipelined MIPS register file with a busy-bit scoreboard and a power-up clear sequencer.
// Latency: reads and Busy are combinational; writes and scoreboard updates land on the next Clk edge.
// Backpressure: none. Ready is low during the clear, and all write/issue inputs are ignored until it rises.
//
// Ports:
//   Clk, Rst              rising-edge clock, asynchronous active-high reset
//   ReadReg1/2 -> DataRead1/2, Busy1/2   combinational read ports and scoreboard lookups
//   WriteReg, WriteData, RegWrite        general writeback port
//   LinkWrite, LinkAddr                  Jal link write (regs[LINK_REG] <= LinkAddr + LINK_INC)
//   IssueValid, IssueReg                 marks a destination register as having a pending producer
//   Ready                                high once every register has been zeroed
//
// Build option: define REGFILE_BYPASS_EN to make same-cycle writes visible on the read ports.

module mips_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int LINK_INC = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] DataRead1,
  output logic [DATA_W-1:0] DataRead2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              LinkWrite,
  input  logic [DATA_W-1:0] LinkAddr,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic              Busy1,
  output logic              Busy2,
  output logic              Ready
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] clrPtr, clrPtrNext;
  logic [DEPTH-1:0]  busy, busyNext;
  logic [DATA_W-1:0] regs [DEPTH];

  logic              run;
  logic              linkWrEn;
  logic              regWrEn;
  logic [DATA_W-1:0] linkData;

  // State register; busy bits share the async reset so a reset drops every pending producer.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= CLEAR;
      clrPtr <= '0;
      busy   <= '0;
    end else begin
      state  <= stateNext;
      clrPtr <= clrPtrNext;
      busy   <= busyNext;
    end
  end

  // Next state: walk the clear pointer once across the array, then run forever.
  always_comb begin
    stateNext  = state;
    clrPtrNext = clrPtr;
    if (state == CLEAR) begin
      clrPtrNext = clrPtr + ADDR_W'(1);
      if (clrPtr == LAST_IDX) stateNext = RUN;
    end
  end

  // State-derived outputs.
  always_comb begin
    run   = (state == RUN);
    Ready = run;
  end

  // Write decode. The link write owns LINK_REG, so a colliding RegWrite is suppressed.
  always_comb begin
    linkData = LinkAddr + DATA_W'(LINK_INC);
    linkWrEn = run && LinkWrite && (LINK_IDX != '0);
    regWrEn  = run && RegWrite && (WriteReg != '0) &&
               !(linkWrEn && (WriteReg == LINK_IDX));
  end

  // Array has no reset of its own; the clear sequencer zeroes one entry per cycle instead.
  always_ff @(posedge Clk) begin
    if (!run) begin
      regs[clrPtr] <= '0;
    end else begin
      if (regWrEn)  regs[WriteReg] <= WriteData;
      if (linkWrEn) regs[LINK_IDX] <= linkData;
    end
  end

  // Read port 1
  always_comb begin
    DataRead1 = '0;
    if (run && (ReadReg1 != '0)) begin
      DataRead1 = regs[ReadReg1];
`ifdef REGFILE_BYPASS_EN
      if (linkWrEn && (ReadReg1 == LINK_IDX))    DataRead1 = linkData;
      else if (regWrEn && (ReadReg1 == WriteReg)) DataRead1 = WriteData;
`endif
    end
  end

  // Read port 2
  always_comb begin
    DataRead2 = '0;
    if (run && (ReadReg2 != '0)) begin
      DataRead2 = regs[ReadReg2];
`ifdef REGFILE_BYPASS_EN
      if (linkWrEn && (ReadReg2 == LINK_IDX))    DataRead2 = linkData;
      else if (regWrEn && (ReadReg2 == WriteReg)) DataRead2 = WriteData;
`endif
    end
  end

  // Scoreboard update. The set is applied last so a new issue outranks a same-cycle writeback.
  always_comb begin
    busyNext = busy;
    if (run) begin
      if (RegWrite && (WriteReg != '0)) busyNext[WriteReg] = 1'b0;
      if (LinkWrite)                    busyNext[LINK_IDX] = 1'b0;
      if (IssueValid && (IssueReg != '0)) busyNext[IssueReg] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  // Busy reflects the registered (pre-edge) bits only.
  always_comb begin
    Busy1 = run && busy[ReadReg1];
    Busy2 = run && busy[ReadReg2];
  end

endmodule

// File: tb/tb_mips_regfile_sb.sv
module tb_mips_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg, IssueReg;
  logic [31:0] DataRead1, DataRead2, WriteData, LinkAddr;
  logic        RegWrite, LinkWrite, IssueValid;
  logic        Busy1, Busy2, Ready;

  logic [31:0] expQ[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc;

  mips_regfile_sb dut (
    .Clk(Clk), .Rst(Rst),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .DataRead1(DataRead1), .DataRead2(DataRead2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .LinkWrite(LinkWrite), .LinkAddr(LinkAddr),
    .IssueValid(IssueValid), .IssueReg(IssueReg),
    .Busy1(Busy1), .Busy2(Busy2), .Ready(Ready)
  );

  always #5 Clk = ~Clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_val(input logic [31:0] v);
    expQ.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] expv;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      expv = expQ.pop_front();
      assert (obs === expv) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
    end
  endtask

  // Counts edges until Ready rises, capped so a stuck sequencer still reaches the summary.
  task automatic wait_ready(output int n);
    n = 0;
    while (Ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    Rst = 1'b1;
    ReadReg1 = '0; ReadReg2 = '0; WriteReg = '0; IssueReg = '0;
    WriteData = '0; LinkAddr = '0;
    RegWrite = 1'b0; LinkWrite = 1'b0; IssueValid = 1'b0;
    tick(); tick();

    // Held in reset
    expect_val(32'd0); check("rst_ready", Ready);
    expect_val(32'd0); check("rst_busy1", Busy1);

    // Clear sequence length after reset release
    Rst = 1'b0;
    wait_ready(cyc);
    expect_val(32'd32); check("clear_cycles", cyc);

    // Every register reads zero after the clear
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #1;
      expect_val(32'd0); check("zero_rd1", DataRead1);
      expect_val(32'd0); check("zero_rd2", DataRead2);
    end
    tick();

    // Writeback to reg 5, read in the same cycle and the next
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF; ReadReg1 = 5'd5;
    #1;
    expect_val(BYP ? 32'hDEADBEEF : 32'h0); check("wr5_same_cycle", DataRead1);
    tick();
    RegWrite = 1'b0;
    #1;
    expect_val(32'hDEADBEEF); check("wr5_next_cycle", DataRead1);

    // Writes to reg 0 are discarded
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678; ReadReg1 = 5'd0; ReadReg2 = 5'd5;
    #1;
    expect_val(32'd0); check("wr0_same_cycle", DataRead1);
    tick();
    RegWrite = 1'b0;
    #1;
    expect_val(32'd0); check("wr0_next_cycle", DataRead1);
    expect_val(32'hDEADBEEF); check("reg5_hold", DataRead2);

    // Link write beats a colliding RegWrite to reg 31
    LinkWrite = 1'b1; LinkAddr = 32'h00400010;
    RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 32'hAAAA0000; ReadReg2 = 5'd31;
    #1;
    expect_val(BYP ? 32'h00400011 : 32'h0); check("link_same_cycle", DataRead2);
    tick();
    LinkWrite = 1'b0; RegWrite = 1'b0;
    #1;
    expect_val(32'h00400011); check("link_wins", DataRead2);

    // Link increment wraps
    LinkWrite = 1'b1; LinkAddr = 32'hFFFFFFFF;
    #1;
    expect_val(BYP ? 32'h0 : 32'h00400011); check("link_wrap_same", DataRead2);
    tick();
    LinkWrite = 1'b0;
    #1;
    expect_val(32'h0); check("link_wrap", DataRead2);

    // Scoreboard: issue sets busy after the edge
    IssueValid = 1'b1; IssueReg = 5'd7; ReadReg1 = 5'd7; ReadReg2 = 5'd8;
    #1;
    expect_val(32'd0); check("busy_pre_issue", Busy1);
    tick();
    IssueValid = 1'b0;
    #1;
    expect_val(32'd1); check("busy_set", Busy1);
    expect_val(32'd0); check("busy_other", Busy2);

    // Same-cycle issue and writeback: set wins
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h00000077;
    IssueValid = 1'b1; IssueReg = 5'd7;
    #1;
    expect_val(32'd1); check("busy_collide_pre", Busy1);
    tick();
    RegWrite = 1'b0; IssueValid = 1'b0;
    #1;
    expect_val(32'd1); check("busy_set_wins", Busy1);
    expect_val(32'h00000077); check("reg7_data", DataRead1);

    // Writeback alone clears, visible only after the edge
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h00000078;
    #1;
    expect_val(32'd1); check("busy_preedge", Busy1);
    tick();
    RegWrite = 1'b0;
    #1;
    expect_val(32'd0); check("busy_cleared", Busy1);

    // Link write clears busy[31]
    IssueValid = 1'b1; IssueReg = 5'd31; ReadReg2 = 5'd31;
    tick();
    IssueValid = 1'b0;
    #1;
    expect_val(32'd1); check("busy31_set", Busy2);
    LinkWrite = 1'b1; LinkAddr = 32'h00000100;
    tick();
    LinkWrite = 1'b0;
    #1;
    expect_val(32'd0); check("busy31_link_clr", Busy2);
    expect_val(32'h00000101); check("link_data", DataRead2);

    // busy[0] is never set
    IssueValid = 1'b1; IssueReg = 5'd0; ReadReg1 = 5'd0;
    tick();
    IssueValid = 1'b0;
    #1;
    expect_val(32'd0); check("busy0", Busy1);

    // Reset during RUN with busy[7] pending
    IssueValid = 1'b1; IssueReg = 5'd7; ReadReg1 = 5'd7;
    tick();
    IssueValid = 1'b0;
    #1;
    expect_val(32'd1); check("busy7_before_rst", Busy1);
    Rst = 1'b1;
    #1;
    expect_val(32'd0); check("rst_async_busy", Busy1);
    expect_val(32'd0); check("rst_async_ready", Ready);
    tick();
    Rst = 1'b0;

    // Writes and issues during the clear are ignored
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h00000BAD;
    IssueValid = 1'b1; IssueReg = 5'd5; ReadReg1 = 5'd5;
    #1;
    expect_val(32'd0); check("clear_read_zero", DataRead1);
    expect_val(32'd0); check("clear_busy_zero", Busy1);

    // Reset again part way through the clear restarts it
    for (int i = 0; i < 10; i++) tick();
    expect_val(32'd0); check("midclear_ready", Ready);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    wait_ready(cyc);
    RegWrite = 1'b0; IssueValid = 1'b0;
    expect_val(32'd32); check("reclear_cycles", cyc);
    #1;
    expect_val(32'd0); check("reg5_cleared", DataRead1);
    expect_val(32'd0); check("busy5_ignored", Busy1);

    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
